// File: rtl/tx_fifo_ctrl_pkg.sv
// Shared constants and helpers for the UART transmit FIFO.
// Defaults match the standard 16-deep byte FIFO in front of the transmit engine.
package tx_fifo_ctrl_pkg;

    localparam int TXF_DEPTH_DEF = 16;
    localparam int TXF_AW        = $clog2(TXF_DEPTH_DEF);
    localparam int TXF_LW        = TXF_AW + 1;
    localparam int TXF_WIDTH     = 8;
    localparam int TXF_AFULL_DEF = 12;

    // A new error always beats a simultaneous clear.
    function automatic logic txfSticky(input logic flag, input logic clr, input logic set);
        return set | (flag & ~clr);
    endfunction

endpackage

// File: rtl/tx_fifo_ram.sv
// Simple dual-port storage for the transmit FIFO.
// Its registered read port is the transmitter-facing data register.
module tx_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Contents are deliberately never cleared so the array can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a pop and a write to the same slot return the old byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tx_fifo_ctrl.sv
// Transmit FIFO controller: pointers, occupancy, status flags and sticky errors.
// The head byte is presented one clock after each active-low pop strobe.
module tx_fifo_ctrl
    import tx_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH     = TXF_DEPTH_DEF,
    parameter int WIDTH     = TXF_WIDTH,
    parameter int AFULL_LVL = TXF_AFULL_DEF,
    localparam int AW       = $clog2(DEPTH),
    localparam int LW       = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             fifo_read_tx,
    input  logic             clr_err,
    output logic [WIDTH-1:0] tx_dout_reg,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             almost_full,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow
);

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [LW-1:0] level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic popReq;
    logic popOk;
    logic wrOk;
    logic ovfSet;
    logic unfSet;
    logic ramWe;
    logic ramRe;

    // A full FIFO still accepts a write when a pop frees the head slot in the same cycle.
    always_comb begin
        popReq = ~fifo_read_tx;
        popOk  = popReq & ~empty_q;
        wrOk   = wr_en & (~full_q | popOk);
        ovfSet = wr_en & full_q & ~popOk;
        unfSet = popReq & empty_q;
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        empty_d = empty_q;
        full_d  = full_q;
        afull_d = afull_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (fifo_flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
            empty_d = 1'b1;
            full_d  = 1'b0;
            afull_d = 1'b0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (wrOk) begin
                wrPtr_d = wrPtr_q + AW'(1);
            end
            if (popOk) begin
                rdPtr_d = rdPtr_q + AW'(1);
            end
            level_d = level_q + LW'(wrOk) - LW'(popOk);
            empty_d = (level_d == '0);
            full_d  = (level_d == LW'(DEPTH));
            afull_d = (level_d >= LW'(AFULL_LVL));
            ovf_d   = txfSticky(ovf_q, clr_err, ovfSet);
            unf_d   = txfSticky(unf_q, clr_err, unfSet);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Flush leaves the data register holding; reset clears it inside the RAM.
    assign ramWe = wrOk & ~fifo_flush & ~reset;
    assign ramRe = popOk & ~fifo_flush & ~reset;

    tx_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ramWe),
        .waddr (wrPtr_q),
        .wdata (wr_data),
        .re    (ramRe),
        .raddr (rdPtr_q),
        .rdata (tx_dout_reg)
    );

    assign fifo_empty  = empty_q;
    assign fifo_full   = full_q;
    assign almost_full = afull_q;
    assign level       = level_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Self-checking bench for tx_fifo_ctrl: a byte queue scoreboard predicts every
// popped byte, the occupancy flags and the sticky error flags after each clock.
module tb_tx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_read_tx = 1'b1;
    logic       clr_err = 1'b0;
    logic [7:0] tx_dout_reg;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_full;
    logic [4:0] level;
    logic       overflow;
    logic       underflow;

    int checkCount = 0;
    int failCount  = 0;

    logic [7:0] expQ[$];
    logic [7:0] expDout = 8'h00;
    logic       expOvf = 1'b0;
    logic       expUnf = 1'b0;

    tx_fifo_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_flush   (fifo_flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_read_tx (fifo_read_tx),
        .clr_err      (clr_err),
        .tx_dout_reg  (tx_dout_reg),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag);
        int n;
        n = expQ.size();
        checkOutput({tag, "_dout"},  32'(tx_dout_reg), 32'(expDout));
        checkOutput({tag, "_level"}, 32'(level),       32'(n));
        checkOutput({tag, "_empty"}, 32'(fifo_empty),  32'(n == 0));
        checkOutput({tag, "_full"},  32'(fifo_full),   32'(n == 16));
        checkOutput({tag, "_afull"}, 32'(almost_full), 32'(n >= 12));
        checkOutput({tag, "_ovf"},   32'(overflow),    32'(expOvf));
        checkOutput({tag, "_unf"},   32'(underflow),   32'(expUnf));
    endtask

    task automatic applyReset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        wr_en        = 1'b0;
        fifo_read_tx = 1'b1;
        fifo_flush   = 1'b0;
        clr_err      = 1'b0;
        expQ.delete();
        expDout = 8'h00;
        expOvf  = 1'b0;
        expUnf  = 1'b0;
        checkState(tag);
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic pop,
                                 input logic flush, input logic clr, input string tag);
        int   n;
        logic popOk;
        logic wrOk;
        logic newOvf;
        logic newUnf;
        n      = expQ.size();
        popOk  = pop && (n > 0);
        wrOk   = wr && ((n < 16) || popOk);
        newOvf = wr && (n == 16) && !popOk;
        newUnf = pop && (n == 0);
        if (flush) begin
            expQ.delete();
            expOvf = 1'b0;
            expUnf = 1'b0;
        end else begin
            if (popOk) expDout = expQ.pop_front();
            if (wrOk) expQ.push_back(d);
            expOvf = newOvf | (expOvf & ~clr);
            expUnf = newUnf | (expUnf & ~clr);
        end
        wr_en        = wr;
        wr_data      = d;
        fifo_read_tx = ~pop;
        fifo_flush   = flush;
        clr_err      = clr;
        @(posedge clk);
        #1;
        wr_en        = 1'b0;
        fifo_read_tx = 1'b1;
        fifo_flush   = 1'b0;
        clr_err      = 1'b0;
        checkState(tag);
    endtask

    task automatic writeByte(input logic [7:0] d, input string tag);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic popByte(input string tag);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, tag);
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, tag);
    endtask

    logic [7:0] txExp [3];
    int         frames;

    initial begin
        txExp = '{8'hC1, 8'hC2, 8'hC3};

        applyReset("reset");

        $display("[TB] basic write then single pop");
        writeByte(8'h41, "t1_wr");
        writeByte(8'h42, "t1_wr");
        writeByte(8'h43, "t1_wr");
        popByte("t1_pop");
        checkOutput("t1_head", 32'(tx_dout_reg), 32'h41);
        checkOutput("t1_lvl2", 32'(level), 32'd2);
        popByte("t1_drain");
        popByte("t1_drain");

        $display("[TB] fill, overflow, clear and drain");
        applyReset("t2_reset");
        for (int i = 0; i < 16; i++) writeByte(8'(i), "t2_fill");
        writeByte(8'hFF, "t2_over");
        checkOutput("t2_isfull", 32'(fifo_full), 32'd1);
        checkOutput("t2_ovfset", 32'(overflow), 32'd1);
        checkOutput("t2_lvl16", 32'(level), 32'd16);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "t2_clr");
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, "t2_clrNew");
        checkOutput("t2_ovfwins", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) popByte("t2_drain");
        checkOutput("t2_last", 32'(tx_dout_reg), 32'h0F);
        checkOutput("t2_isempty", 32'(fifo_empty), 32'd1);

        $display("[TB] pop on empty while writing");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "t3_clr");
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, "t3_wrpop");
        checkOutput("t3_unfset", 32'(underflow), 32'd1);
        checkOutput("t3_hold", 32'(tx_dout_reg), 32'h0F);
        popByte("t3_pop");
        checkOutput("t3_byte", 32'(tx_dout_reg), 32'h55);

        $display("[TB] full with simultaneous write and pop");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "t4_clr");
        for (int i = 0; i < 16; i++) writeByte(8'(8'h10 + i), "t4_fill");
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, "t4_both");
        checkOutput("t4_lvl16", 32'(level), 32'd16);
        checkOutput("t4_noovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 15; i++) popByte("t4_drain");
        popByte("t4_wrap");
        checkOutput("t4_aa", 32'(tx_dout_reg), 32'hAA);

        $display("[TB] flush and mid-stream reset");
        popByte("t5_unf");
        for (int i = 0; i < 10; i++) writeByte(8'(8'h80 + i), "t5_fill");
        checkOutput("t5_lvl10", 32'(level), 32'd10);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, "t5_flush");
        checkOutput("t5_flushunf", 32'(underflow), 32'd0);
        for (int i = 0; i < 5; i++) writeByte(8'(8'h60 + i), "t5_refill");
        popByte("t5_pop");
        wr_en        = 1'b1;
        wr_data      = 8'h66;
        fifo_read_tx = 1'b0;
        applyReset("t5_rst");
        checkOutput("t5_rstdout", 32'(tx_dout_reg), 32'h00);
        writeByte(8'h77, "t5_wr");
        popByte("t5_rt");
        checkOutput("t5_roundtrip", 32'(tx_dout_reg), 32'h77);

        $display("[TB] transmit engine draining three bytes");
        writeByte(8'hC1, "t6_wr");
        writeByte(8'hC2, "t6_wr");
        writeByte(8'hC3, "t6_wr");
        frames = 0;
        for (int k = 0; k < 8 && fifo_empty == 1'b0; k++) begin
            popByte("t6_strobe");
            idleCycle("t6_wait");
            idleCycle("t6_start");
            if (frames < 3) checkOutput("t6_frame", 32'(tx_dout_reg), 32'(txExp[frames]));
            frames++;
        end
        checkOutput("t6_frames", 32'(frames), 32'd3);
        checkOutput("t6_nounf", 32'(underflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
